adc_avg_sequencer: RTL and testbench

Parametrised conversion sequencer and averager sitting between the SPI command interface and the SAR ADC.
- On a start request it walks the enabled channels in ascending order and requests 2^L conversions per channel.
- It accumulates the conversions, rounds the result and stores one word per channel in a result bank that the readout path reads by channel index.
- It generalises the fixed 16-channel, 14-bit, 16-sample averaging path to configurable channel count, ADC width and run-time averaging depth, and adds a conversion timeout.

---
 rtl/adc_avg_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_adc_avg_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_avg_sequencer.sv
// Conversion sequencer and averager between the SPI command path and the SAR ADC.
// Walks enabled channels, averages 2^L conversions each, and keeps one rounded word per channel.
module adc_avg_sequencer #(
  parameter int unsigned NUMCHANNELS    = 16,
  parameter int unsigned ADCBITDEPTH    = 14,
  parameter int unsigned OUTWIDTH       = 16,
  parameter int unsigned MAX_AVG_LOG2   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned CHW  = (NUMCHANNELS > 1) ? $clog2(NUMCHANNELS) : 1,
  localparam int unsigned AVGW = $clog2(MAX_AVG_LOG2 + 1)
) (
  input  logic                   CLK,
  input  logic                   NRST,
  input  logic                   START,
  input  logic [NUMCHANNELS-1:0] CH_ENABLE,
  input  logic [AVGW-1:0]        AVG_LOG2,
  output logic                   SAMPLE,
  output logic [CHW-1:0]         MUX_chan,
  input  logic                   READY,
  input  logic [ADCBITDEPTH-1:0] DOUT,
  output logic                   BUSY,
  output logic                   DATA_RDY,
  output logic                   TIMEOUT_ERR,
  input  logic                   DATA_CLR,
  input  logic [CHW-1:0]         RD_CHAN,
  output logic [OUTWIDTH-1:0]    RD_DATA
);

  localparam int unsigned ACCW = ADCBITDEPTH + MAX_AVG_LOG2;
  localparam int unsigned CNTW = MAX_AVG_LOG2 + 1;
  localparam int unsigned TMW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [OUTWIDTH-1:0] RESET_WORD = {1'b1, {(OUTWIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_REQ, S_WAIT, S_STORE, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [CHW-1:0]           chan_q, chan_d;
  logic [NUMCHANNELS-1:0]   en_q, en_d;
  logic [AVGW-1:0]          avg_q, avg_d;
  logic [ACCW-1:0]          acc_q, acc_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic [TMW-1:0]           tmo_q, tmo_d;
  logic                     busy_q, busy_d;
  logic                     data_rdy_q, data_rdy_d;
  logic                     tmo_err_q, tmo_err_d;
  logic [OUTWIDTH-1:0]      rd_data_q, rd_data_d;
  logic [OUTWIDTH-1:0]      bank_q [NUMCHANNELS];

  logic                     bank_we;
  logic [OUTWIDTH-1:0]      bank_wdata;
  logic                     last_chan;
  logic [CNTW-1:0]          cnt_inc;
  logic [CNTW-1:0]          cnt_target;
  logic [ACCW-1:0]          rnd_sum;

  assign last_chan  = (chan_q == CHW'(NUMCHANNELS - 1));
  assign cnt_inc    = cnt_q + CNTW'(1);
  assign cnt_target = CNTW'(1) << avg_q;
  // Round-half-up: add half an LSB of the shifted result before dividing by 2^L.
  assign rnd_sum    = acc_q + ((ACCW'(1) << avg_q) >> 1);

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    en_d       = en_q;
    avg_d      = avg_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    busy_d     = busy_q;
    data_rdy_d = data_rdy_q;
    tmo_err_d  = tmo_err_q;
    bank_we    = 1'b0;
    bank_wdata = RESET_WORD;
    rd_data_d  = bank_q[RD_CHAN];

    // Host clear first so a same-cycle set in DONE overrides it.
    if (DATA_CLR) data_rdy_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          en_d       = CH_ENABLE;
          avg_d      = (AVG_LOG2 > AVGW'(MAX_AVG_LOG2)) ? AVGW'(MAX_AVG_LOG2) : AVG_LOG2;
          chan_d     = '0;
          acc_d      = '0;
          cnt_d      = '0;
          data_rdy_d = 1'b0;
          tmo_err_d  = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (en_q[chan_q]) begin
          state_d = S_REQ;
        end else begin
          bank_we    = 1'b1;
          bank_wdata = RESET_WORD;
          if (last_chan) state_d = S_DONE;
          else           chan_d  = chan_q + CHW'(1);
        end
      end
      S_REQ: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (READY) begin
          acc_d   = acc_q + ACCW'(DOUT);
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == cnt_target) ? S_STORE : S_REQ;
        end else if (tmo_q == TMW'(TIMEOUT_CYCLES - 1)) begin
          tmo_err_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMW'(1);
        end
      end
      S_STORE: begin
        bank_we    = 1'b1;
        bank_wdata = OUTWIDTH'(rnd_sum >> avg_q);
        acc_d      = '0;
        cnt_d      = '0;
        if (last_chan) begin
          state_d = S_DONE;
        end else begin
          chan_d  = chan_q + CHW'(1);
          state_d = S_SCAN;
        end
      end
      S_DONE: begin
        busy_d     = 1'b0;
        data_rdy_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q    <= S_IDLE;
      chan_q     <= '0;
      en_q       <= '0;
      avg_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
      data_rdy_q <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      en_q       <= en_d;
      avg_q      <= avg_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      busy_q     <= busy_d;
      data_rdy_q <= data_rdy_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      for (int unsigned i = 0; i < NUMCHANNELS; i++) bank_q[i] <= RESET_WORD;
      rd_data_q <= RESET_WORD;
    end else begin
      if (bank_we) bank_q[chan_q] <= bank_wdata;
      rd_data_q <= rd_data_d;
    end
  end

  assign SAMPLE      = (state_q == S_REQ);
  assign MUX_chan    = chan_q;
  assign BUSY        = busy_q;
  assign DATA_RDY    = data_rdy_q;
  assign TIMEOUT_ERR = tmo_err_q;
  assign RD_DATA     = rd_data_q;

endmodule

// File: tb/tb_adc_avg_sequencer.sv
// Directed, table-driven bench for adc_avg_sequencer with a simple responsive ADC model.
module tb_adc_avg_sequencer;

  logic        CLK = 1'b0;
  logic        NRST;
  logic        START;
  logic [15:0] CH_ENABLE;
  logic [2:0]  AVG_LOG2;
  logic        SAMPLE;
  logic [3:0]  MUX_chan;
  logic        READY;
  logic [13:0] DOUT;
  logic        BUSY;
  logic        DATA_RDY;
  logic        TIMEOUT_ERR;
  logic        DATA_CLR;
  logic [3:0]  RD_CHAN;
  logic [15:0] RD_DATA;

  always #5 CLK = ~CLK;

  adc_avg_sequencer #(
    .NUMCHANNELS(16),
    .ADCBITDEPTH(14),
    .OUTWIDTH(16),
    .MAX_AVG_LOG2(4),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .CLK(CLK), .NRST(NRST), .START(START), .CH_ENABLE(CH_ENABLE), .AVG_LOG2(AVG_LOG2),
    .SAMPLE(SAMPLE), .MUX_chan(MUX_chan), .READY(READY), .DOUT(DOUT), .BUSY(BUSY),
    .DATA_RDY(DATA_RDY), .TIMEOUT_ERR(TIMEOUT_ERR), .DATA_CLR(DATA_CLR),
    .RD_CHAN(RD_CHAN), .RD_DATA(RD_DATA)
  );

  typedef struct {
    logic [15:0]       en;
    logic [2:0]        l;
    int                mode;
    int                exp_samples;
    int                exp_lat;
    logic [15:0][15:0] exp_res;
  } vec_t;

  vec_t vecs[5];
  vec_t tv;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // mode 0: 0x100+n on conversion n; 1/4: idx+8*ch; 2: rounding-edge samples
  function automatic logic [13:0] adc_val(input int mode, input int ch, input int idx, input int n);
    case (mode)
      0:       return 14'(256 + n);
      1, 4:    return 14'(idx + 8 * ch);
      2: begin
        if (ch == 0)      return (idx < 15) ? 14'd16 : 14'd23;
        else if (ch == 1) return (idx < 15) ? 14'd16 : 14'd24;
        else              return 14'h3FFF;
      end
      default: return 14'd0;
    endcase
  endfunction

  task automatic read_bank(input string tag, input logic [15:0][15:0] exp);
    for (int k = 0; k < 16; k++) begin
      RD_CHAN = 4'(k);
      tick();
      check($sformatf("%s_res_ch%0d", tag, k), RD_DATA, exp[k]);
    end
  endtask

  // Runs one frame; returns SAMPLE count, cycle at which BUSY fell, and cycle of the withheld request.
  task automatic run_frame(input vec_t v, output int samples, output int cyc, output int wcyc);
    int          cur;
    int          idx;
    int          n;
    int          ch;
    logic        pend;
    logic [13:0] pend_val;
    CH_ENABLE = v.en;
    AVG_LOG2  = v.l;
    START     = 1'b1;
    READY     = 1'b1;
    DOUT      = '1;
    tick();
    cyc       = 1;
    START     = 1'b0;
    READY     = 1'b0;
    CH_ENABLE = ~v.en;
    AVG_LOG2  = 3'd0;
    check("busy_after_start", BUSY, 1);
    pend = 1'b0; pend_val = '0; samples = 0; n = 0; cur = -1; idx = 0; wcyc = -1;
    while (BUSY && cyc < 5000) begin
      READY = 1'b0;
      if (pend) begin
        READY = 1'b1;
        DOUT  = pend_val;
        pend  = 1'b0;
      end
      if (SAMPLE) begin
        samples++;
        ch = int'(MUX_chan);
        if (ch != cur) begin
          cur = ch;
          idx = 0;
        end
        if (v.mode == 4 && ch == 3 && idx == 1) begin
          wcyc = cyc;
        end else begin
          pend     = 1'b1;
          pend_val = adc_val(v.mode, ch, idx, n);
        end
        idx++;
        n++;
      end
      START = (cyc == 10);
      tick();
      cyc++;
    end
    START = 1'b0;
    READY = 1'b0;
    if (cyc >= 5000) check("frame_cycle_budget", 32'(cyc), 32'd0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int s, c, w;
    run_frame(v, s, c, w);
    check({tag, "_samples"}, 32'(s), 32'(v.exp_samples));
    if (v.exp_lat >= 0) check({tag, "_data_rdy_latency"}, 32'(c), 32'(v.exp_lat));
    check({tag, "_data_rdy"}, DATA_RDY, 1);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_timeout_err"}, TIMEOUT_ERR, 0);
    read_bank(tag, v.exp_res);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, c, w, smp;
    logic [15:0][15:0] exp;

    // Vector table
    vecs[0].en = 16'hFFFF; vecs[0].l = 3'd0; vecs[0].mode = 0; vecs[0].exp_samples = 16; vecs[0].exp_lat = 66;
    for (int k = 0; k < 16; k++) vecs[0].exp_res[k] = 16'(16'h0100 + k);
    vecs[1].en = 16'h02FF; vecs[1].l = 3'd4; vecs[1].mode = 1; vecs[1].exp_samples = 144; vecs[1].exp_lat = -1;
    for (int k = 0; k < 16; k++) vecs[1].exp_res[k] = (k <= 7 || k == 9) ? 16'(8 + 8 * k) : 16'h8000;
    vecs[2].en = 16'h0007; vecs[2].l = 3'd4; vecs[2].mode = 2; vecs[2].exp_samples = 48; vecs[2].exp_lat = -1;
    for (int k = 0; k < 16; k++) vecs[2].exp_res[k] = 16'h8000;
    vecs[2].exp_res[0] = 16'h0010; vecs[2].exp_res[1] = 16'h0011; vecs[2].exp_res[2] = 16'h3FFF;
    vecs[3].en = 16'h0003; vecs[3].l = 3'd7; vecs[3].mode = 1; vecs[3].exp_samples = 32; vecs[3].exp_lat = -1;
    for (int k = 0; k < 16; k++) vecs[3].exp_res[k] = 16'h8000;
    vecs[3].exp_res[0] = 16'h0008; vecs[3].exp_res[1] = 16'h0010;
    vecs[4].en = 16'h0000; vecs[4].l = 3'd0; vecs[4].mode = 0; vecs[4].exp_samples = 0; vecs[4].exp_lat = 18;
    for (int k = 0; k < 16; k++) vecs[4].exp_res[k] = 16'h8000;

    NRST = 1'b0; START = 1'b0; CH_ENABLE = '0; AVG_LOG2 = '0; READY = 1'b0;
    DOUT = '0; DATA_CLR = 1'b0; RD_CHAN = '0;
    tick(); tick();
    check("rst_sample", SAMPLE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_data_rdy", DATA_RDY, 0);
    check("rst_timeout_err", TIMEOUT_ERR, 0);
    check("rst_mux_chan", MUX_chan, 0);
    check("rst_rd_data", RD_DATA, 16'h8000);
    NRST = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // DATA_CLR drops DATA_RDY on the next cycle
    DATA_CLR = 1'b1;
    tick();
    DATA_CLR = 1'b0;
    check("data_clr", DATA_RDY, 0);

    // All-disabled frame with DATA_CLR in the DONE cycle: the set wins
    CH_ENABLE = 16'h0000; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (16) tick();
    DATA_CLR = 1'b1;
    tick();
    check("set_wins_over_clr", DATA_RDY, 1);
    check("set_wins_busy", BUSY, 0);
    tick();
    check("clr_after_set", DATA_RDY, 0);
    DATA_CLR = 1'b0;

    // Timeout on channel 3's second sample, after a frame that leaves 0x100+k in the bank
    run_vec("pre_tmo", vecs[0]);
    tv.en = 16'hFFFF; tv.l = 3'd1; tv.mode = 4; tv.exp_samples = 8; tv.exp_lat = -1;
    run_frame(tv, s, c, w);
    check("tmo_latency", 32'(c - w), 32'd256);
    check("tmo_samples", 32'(s), 32'd8);
    check("tmo_err", TIMEOUT_ERR, 1);
    check("tmo_busy", BUSY, 0);
    check("tmo_data_rdy", DATA_RDY, 0);
    for (int k = 0; k < 16; k++) exp[k] = (k < 3) ? 16'(1 + 8 * k) : 16'(16'h0100 + k);
    read_bank("tmo", exp);

    tv.mode = 1; tv.exp_samples = 32;
    for (int k = 0; k < 16; k++) tv.exp_res[k] = 16'(1 + 8 * k);
    run_vec("post_tmo", tv);

    // Mid-frame reset
    CH_ENABLE = 16'hFFF0; AVG_LOG2 = 3'd2; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (20) tick();
    check("pre_rst_busy", BUSY, 1);
    check("pre_rst_chan", MUX_chan, 4);
    NRST = 1'b0;
    tick();
    NRST = 1'b1;
    check("midrst_sample", SAMPLE, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_data_rdy", DATA_RDY, 0);
    check("midrst_timeout_err", TIMEOUT_ERR, 0);
    check("midrst_mux_chan", MUX_chan, 0);
    check("midrst_rd_data", RD_DATA, 16'h8000);
    smp = 0;
    for (int i = 0; i < 5; i++) begin
      READY = 1'b1;
      tick();
      if (SAMPLE) smp++;
    end
    READY = 1'b0;
    check("midrst_idle_samples", 32'(smp), 32'd0);
    for (int k = 0; k < 16; k++) exp[k] = 16'h8000;
    read_bank("midrst", exp);

    run_vec("final", vecs[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
